// File: rtl/pool_stream_engine_pkg.sv
// Shared constants, row-parity state type and elaboration helpers for the
// 2x2/stride-2 pooling engine.
package pool_pkg;

  localparam logic POOL_MAX = 1'b0;
  localparam logic POOL_AVG = 1'b1;

  typedef enum logic {StEvenRow, StOddRow} row_state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r = r + 1;
    return r;
  endfunction

  // Low bit index of a lane inside a packed multi-lane vector.
  function automatic int unsigned lane_lo(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

endpackage

// File: rtl/pool_stream_engine_if.sv
// Stream-side signals of the pooling engine: pixel input, pooled output and
// per-frame controls.
interface pool_stream_engine_if #(
  parameter int unsigned CH = 6,
  parameter int unsigned DW = 16
);
  logic             pool_clr;
  logic             mode;
  logic             in_valid;
  logic             in_ready;
  logic [CH*DW-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [CH*DW-1:0] out_data;
  logic             out_last;

  modport master (
    output pool_clr, mode, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  pool_clr, mode, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/pool_stream_engine_lane.sv
// Per-lane combine: signed max or widened sum of two sign-extended samples.
module pool_lane
  import pool_pkg::*;
#(
  parameter int unsigned DW = 16
) (
  input  logic               mode,
  input  logic signed [DW+1:0] a,
  input  logic signed [DW+1:0] b,
  output logic signed [DW+1:0] y
);

  always_comb begin
    if (mode == POOL_AVG) y = a + b;
    else                  y = (a > b) ? a : b;
  end

endmodule

// File: rtl/pool_stream_engine.sv
// 2x2/stride-2 max/average pooling over a raster pixel stream, using a hold
// register for the horizontal pair and a half-width row buffer for the vertical pair.
module pool_stream_engine
  import pool_pkg::*;
#(
  parameter int unsigned CH    = 6,
  parameter int unsigned DW    = 16,
  parameter int unsigned IMG_W = 28,
  parameter int unsigned IMG_H = 28
) (
  input  logic               clk,
  input  logic               rst,
  pool_stream_engine_if.slave bus
);

  localparam int unsigned CW = (clog2(IMG_W) > 0) ? clog2(IMG_W) : 1;
  localparam int unsigned RW = (clog2(IMG_H) > 0) ? clog2(IMG_H) : 1;
  localparam int unsigned BW = (CW > 1) ? CW - 1 : 1;
  localparam int unsigned NB = IMG_W / 2;
  localparam int unsigned LW = DW + 2;
  localparam logic [CW-1:0] ColLast = CW'(IMG_W - 1);
  localparam logic [RW-1:0] RowLast = RW'(IMG_H - 1);

  row_state_e       state_q, state_d;
  logic [CW-1:0]    col_q, col_d;
  logic [RW-1:0]    row_q, row_d;
  logic             mode_q, mode_d;
  logic [CH*DW-1:0] h_q, h_d;
  logic             out_valid_q, out_valid_d;
  logic [CH*DW-1:0] out_data_q, out_data_d;
  logic             out_last_q, out_last_d;

  logic [CH*LW-1:0] row_buf [NB];

  logic             xfer, first_px, col_odd, col_end, row_end, cur_mode;
  logic [BW-1:0]    bidx;
  logic [CH*LW-1:0] buf_rd, hsum, vsum;
  logic [CH*DW-1:0] res;

  assign bus.in_ready  = !out_valid_q | bus.out_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;

  assign xfer     = bus.in_valid & bus.in_ready & !bus.pool_clr;
  assign first_px = (col_q == '0) && (row_q == '0);
  // The (0,0) pixel already uses the mode being latched on its own transfer.
  assign cur_mode = first_px ? bus.mode : mode_q;
  assign col_odd  = col_q[0];
  assign col_end  = (col_q == ColLast);
  assign row_end  = (row_q == RowLast);
  assign bidx     = BW'(col_q >> 1);
  assign buf_rd   = row_buf[bidx];

  for (genvar c = 0; c < CH; c++) begin : g_lane
    localparam int unsigned Lo  = lane_lo(c, DW);
    localparam int unsigned LoW = lane_lo(c, LW);
    logic signed [LW-1:0] h_ext, in_ext, hs, vs;

    assign h_ext  = {{2{h_q[Lo+DW-1]}}, h_q[Lo +: DW]};
    assign in_ext = {{2{bus.in_data[Lo+DW-1]}}, bus.in_data[Lo +: DW]};

    pool_lane #(.DW(DW)) u_horiz (.mode(cur_mode), .a(h_ext), .b(in_ext), .y(hs));
    pool_lane #(.DW(DW)) u_vert (.mode(cur_mode), .a(buf_rd[LoW +: LW]), .b(hs), .y(vs));

    assign hsum[LoW +: LW] = hs;
    assign vsum[LoW +: LW] = vs;
    // Dropping the two LSBs of the 4-sample sum is floor(sum/4).
    assign res[Lo +: DW]   = (cur_mode == POOL_AVG) ? vs[DW+1:2] : vs[DW-1:0];
  end

  always_ff @(posedge clk) begin
    if (xfer && (state_q == StEvenRow) && col_odd) row_buf[bidx] <= hsum;
  end

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    mode_d      = mode_q;
    h_d         = h_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    if (bus.pool_clr) begin
      state_d     = StEvenRow;
      col_d       = '0;
      row_d       = '0;
      h_d         = '0;
      out_valid_d = 1'b0;
    end else begin
      if (bus.out_ready) out_valid_d = 1'b0;
      if (xfer) begin
        if (first_px) mode_d = bus.mode;
        if (!col_odd) h_d = bus.in_data;
        if (col_end) begin
          col_d   = '0;
          row_d   = row_end ? '0 : row_q + 1'b1;
          state_d = (state_q == StEvenRow) ? StOddRow : StEvenRow;
        end else begin
          col_d = col_q + 1'b1;
        end
        if ((state_q == StOddRow) && col_odd) begin
          out_valid_d = 1'b1;
          out_data_d  = res;
          out_last_d  = row_end && col_end;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StEvenRow;
      col_q       <= '0;
      row_q       <= '0;
      mode_q      <= POOL_MAX;
      h_q         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      mode_q      <= mode_d;
      h_q         <= h_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

endmodule

// File: tb/tb_pool_stream_engine.sv
// Directed bench for pool_stream_engine on a 2-lane 4x4 map with hand-computed outputs.
module tb_pool_stream_engine;

  localparam int unsigned CH = 2;
  localparam int unsigned DW = 16;
  localparam int unsigned IW = 4;
  localparam int unsigned IH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pool_stream_engine_if #(.CH(CH), .DW(DW)) pif ();

  pool_stream_engine #(.CH(CH), .DW(DW), .IMG_W(IW), .IMG_H(IH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (pif)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] q_data[$];
  logic        q_last[$];

  function automatic logic [31:0] pk(input int a, input int b);
    logic [15:0] la, lb;
    la = a[15:0];
    lb = b[15:0];
    return {lb, la};
  endfunction

  function automatic logic [31:0] pix(input int kind, input int idx);
    case (kind)
      0:       return pk(idx, -idx);
      1:       return 32'h7FFF_7FFF;
      default: return 32'h8000_8000;
    endcase
  endfunction

  // Streams npx pixels, optionally stalling out_ready once on the first output,
  // and collects every output transfer into q_data/q_last.
  task automatic drive_frame(input logic m0, input logic m1, input int kind, input int stall,
                             input int npx);
    int sent, tail, guard, stall_left;
    bit stalled_once;
    logic [31:0] held;
    sent = 0; tail = 0; guard = 0; stall_left = 0; stalled_once = 0; held = '0;
    q_data.delete();
    q_last.delete();
    while (1) begin
      @(negedge clk);
      guard++;
      if (guard > 400) begin
        n_checks++;
        $display("FAIL frame_timeout sent=%0d required=%0d", sent, npx);
        break;
      end
      if (stall > 0 && !stalled_once && pif.out_valid) begin
        stalled_once = 1;
        stall_left   = stall;
        held         = pif.out_data;
      end
      pif.out_ready = (stall_left == 0);
      pif.in_valid  = (sent < npx);
      pif.in_data   = pix(kind, sent);
      pif.mode      = (sent == 0) ? m0 : m1;
      #1;
      if (stall_left > 0) begin
        n_checks++;
        if (pif.out_data !== held || pif.in_ready !== 1'b0 || pif.out_valid !== 1'b1)
          $display("FAIL stall_hold data=%h required=%h in_ready=%b required=0 out_valid=%b",
                   pif.out_data, held, pif.in_ready, pif.out_valid);
        else n_pass++;
        stall_left--;
      end
      if (pif.out_valid && pif.out_ready) begin
        q_data.push_back(pif.out_data);
        q_last.push_back(pif.out_last);
      end
      if (pif.in_valid && pif.in_ready) sent++;
      if (sent >= npx) begin
        tail++;
        if (tail > 3 && !pif.out_valid) break;
      end
    end
    pif.in_valid  = 1'b0;
    pif.out_ready = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    pif.pool_clr = 1'b0; pif.mode = 1'b0; pif.in_valid = 1'b0;
    pif.in_data = '0; pif.out_ready = 1'b0;
    #12;
    n_checks++;
    if (pif.in_ready !== 1'b1 || pif.out_valid !== 1'b0 || pif.out_data !== 32'h0 ||
        pif.out_last !== 1'b0)
      $display("FAIL reset_values in_ready=%b out_valid=%b out_data=%h out_last=%b required 1 0 0 0",
               pif.in_ready, pif.out_valid, pif.out_data, pif.out_last);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    pif.out_ready = 1'b1;
  endtask

  task automatic test_max;
    logic [31:0] e [4];
    e = '{pk(5, 0), pk(7, -2), pk(13, -8), pk(15, -10)};
    drive_frame(1'b0, 1'b0, 0, 0, 16);
    n_checks++;
    if (q_data.size() != 4) $display("FAIL max_count got=%0d required=4", q_data.size());
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (i >= q_data.size()) $display("FAIL max_out%0d missing required=%h", i, e[i]);
      else if (q_data[i] !== e[i] || q_last[i] !== (i == 3))
        $display("FAIL max_out%0d got=%h last=%b required=%h last=%b", i, q_data[i], q_last[i],
                 e[i], (i == 3));
      else n_pass++;
    end
  endtask

  task automatic test_avg;
    logic [31:0] e [4];
    e = '{pk(2, -3), pk(4, -5), pk(10, -11), pk(12, -13)};
    drive_frame(1'b1, 1'b1, 0, 0, 16);
    n_checks++;
    if (q_data.size() != 4) $display("FAIL avg_count got=%0d required=4", q_data.size());
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (i >= q_data.size()) $display("FAIL avg_out%0d missing required=%h", i, e[i]);
      else if (q_data[i] !== e[i] || q_last[i] !== (i == 3))
        $display("FAIL avg_out%0d got=%h last=%b required=%h last=%b", i, q_data[i], q_last[i],
                 e[i], (i == 3));
      else n_pass++;
    end
  endtask

  task automatic test_saturation;
    logic [31:0] e [2];
    e = '{32'h7FFF_7FFF, 32'h8000_8000};
    for (int k = 0; k < 2; k++) begin
      drive_frame(1'b1, 1'b1, k + 1, 0, 16);
      n_checks++;
      if (q_data.size() != 4) $display("FAIL sat%0d_count got=%0d required=4", k, q_data.size());
      else n_pass++;
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (i >= q_data.size()) $display("FAIL sat%0d_out%0d missing required=%h", k, i, e[k]);
        else if (q_data[i] !== e[k])
          $display("FAIL sat%0d_out%0d got=%h required=%h", k, i, q_data[i], e[k]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] e [4];
    e = '{pk(5, 0), pk(7, -2), pk(13, -8), pk(15, -10)};
    drive_frame(1'b0, 1'b0, 0, 5, 16);
    n_checks++;
    if (q_data.size() != 4) $display("FAIL bp_count got=%0d required=4", q_data.size());
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (i >= q_data.size()) $display("FAIL bp_out%0d missing required=%h", i, e[i]);
      else if (q_data[i] !== e[i] || q_last[i] !== (i == 3))
        $display("FAIL bp_out%0d got=%h last=%b required=%h", i, q_data[i], q_last[i], e[i]);
      else n_pass++;
    end
  endtask

  task automatic test_clear_and_mode;
    logic [31:0] e [4];
    e = '{pk(5, 0), pk(7, -2), pk(13, -8), pk(15, -10)};
    // Max latched at (0,0); the switch to average afterwards must be ignored.
    drive_frame(1'b0, 1'b1, 0, 0, 16);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (i >= q_data.size()) $display("FAIL mode_hold_out%0d missing required=%h", i, e[i]);
      else if (q_data[i] !== e[i])
        $display("FAIL mode_hold_out%0d got=%h required=%h", i, q_data[i], e[i]);
      else n_pass++;
    end
    // Abort an average frame at row 1 col 0, then a clean max frame.
    drive_frame(1'b1, 1'b1, 0, 0, 5);
    n_checks++;
    if (q_data.size() != 0) $display("FAIL partial_count got=%0d required=0", q_data.size());
    else n_pass++;
    @(negedge clk);
    pif.pool_clr = 1'b1;
    pif.in_valid = 1'b1;
    pif.in_data  = pix(0, 5);
    @(negedge clk);
    pif.pool_clr = 1'b0;
    pif.in_valid = 1'b0;
    n_checks++;
    if (pif.out_valid !== 1'b0) $display("FAIL clr_out_valid got=%b required=0", pif.out_valid);
    else n_pass++;
    drive_frame(1'b0, 1'b0, 0, 0, 16);
    n_checks++;
    if (q_data.size() != 4) $display("FAIL clr_count got=%0d required=4", q_data.size());
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (i >= q_data.size()) $display("FAIL clr_out%0d missing required=%h", i, e[i]);
      else if (q_data[i] !== e[i] || q_last[i] !== (i == 3))
        $display("FAIL clr_out%0d got=%h last=%b required=%h", i, q_data[i], q_last[i], e[i]);
      else n_pass++;
    end
  endtask

  task automatic test_async_reset;
    logic [31:0] e [4];
    e = '{pk(5, 0), pk(7, -2), pk(13, -8), pk(15, -10)};
    drive_frame(1'b0, 1'b0, 0, 0, 13);
    @(negedge clk);
    pif.out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (pif.in_ready !== 1'b1 || pif.out_valid !== 1'b0 || pif.out_data !== 32'h0 ||
        pif.out_last !== 1'b0)
      $display("FAIL async_rst in_ready=%b out_valid=%b out_data=%h out_last=%b required 1 0 0 0",
               pif.in_ready, pif.out_valid, pif.out_data, pif.out_last);
    else n_pass++;
    #1 rst = 1'b0;
    pif.out_ready = 1'b1;
    drive_frame(1'b0, 1'b0, 0, 0, 16);
    n_checks++;
    if (q_data.size() != 4) $display("FAIL rst_count got=%0d required=4", q_data.size());
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (i >= q_data.size()) $display("FAIL rst_out%0d missing required=%h", i, e[i]);
      else if (q_data[i] !== e[i] || q_last[i] !== (i == 3))
        $display("FAIL rst_out%0d got=%h last=%b required=%h", i, q_data[i], q_last[i], e[i]);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_max();
    test_avg();
    test_saturation();
    test_backpressure();
    test_clear_and_mode();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
